// File: rtl/dmem_block_engine.sv
// rtl/dmem_block_engine.sv - block FILL/SUM/COPY initiator for the single-port data memory
module dmem_block_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] fill_value_i,
    input  logic [DATA_W-1:0] fill_step_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SUM,
        S_CP_RD,
        S_CP_WR,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;      // next source / fill address to present
    logic [ADDR_W-1:0]   dst_q;      // next copy destination address
    logic [DATA_W-1:0]   val_q;      // next fill word
    logic [DATA_W-1:0]   step_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    left_q;     // accesses remaining, including the one on the bus
    logic [DATA_W-1:0]   acc_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   result_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;

    logic [ADDR_W-1:0]   src_d;
    logic [ADDR_W-1:0]   dst_d;
    logic [DATA_W-1:0]   val_d;
    logic [DATA_W-1:0]   acc_d;
    logic [CNT_W-1:0]    left_d;
    logic                last_d;

    // Address/value stepping and the running checksum; all wrap silently.
    always_comb begin
        src_d  = src_q + STRIDE_A;
        dst_d  = dst_q + STRIDE_A;
        val_d  = val_q + step_q;
        acc_d  = acc_q + mem_read_data_i;
        left_d = left_q - CNT_ONE;
        last_d = (left_q == CNT_ONE);
    end

    // Command FSM; every bus signal is registered and zero outside active states.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            val_q    <= '0;
            step_q   <= '0;
            count_q  <= '0;
            left_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        result_q <= '0;
                        err_q    <= 1'b0;
                        count_q  <= count_i;
                        left_q   <= count_i;
                        step_q   <= fill_step_i;
                        dst_q    <= dst_addr_i;
                        acc_q    <= '0;
                        if (op_i == 2'b11) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (count_i == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q <= 1'b1;
                            addr_q <= src_addr_i;
                            src_q  <= src_addr_i + STRIDE_A;
                            case (op_i)
                                2'b00: begin
                                    wr_q    <= 1'b1;
                                    wdata_q <= fill_value_i;
                                    val_q   <= fill_value_i + fill_step_i;
                                    state_q <= S_FILL;
                                end
                                2'b01: begin
                                    rd_q    <= 1'b1;
                                    state_q <= S_SUM;
                                end
                                default: begin
                                    rd_q    <= 1'b1;
                                    state_q <= S_CP_RD;
                                end
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    left_q <= left_d;
                    if (last_d) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= DATA_W'(count_q);
                        wr_q     <= 1'b0;
                        addr_q   <= '0;
                        wdata_q  <= '0;
                    end else begin
                        addr_q  <= src_q;
                        wdata_q <= val_q;
                        src_q   <= src_d;
                        val_q   <= val_d;
                    end
                end
                S_SUM: begin
                    left_q <= left_d;
                    if (last_d) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        rd_q     <= 1'b0;
                        addr_q   <= '0;
                    end else begin
                        acc_q  <= acc_d;
                        addr_q <= src_q;
                        src_q  <= src_d;
                    end
                end
                S_CP_RD: begin
                    // The write-data register doubles as the latch for the word just read.
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_q;
                    wdata_q <= mem_read_data_i;
                    dst_q   <= dst_d;
                    state_q <= S_CP_WR;
                end
                S_CP_WR: begin
                    left_q  <= left_d;
                    wr_q    <= 1'b0;
                    wdata_q <= '0;
                    if (last_d) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= DATA_W'(count_q);
                        addr_q   <= '0;
                    end else begin
                        rd_q    <= 1'b1;
                        addr_q  <= src_q;
                        src_q   <= src_d;
                        state_q <= S_CP_RD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign result_o         = result_q;
    assign mem_address_o    = addr_q;
    assign mem_write_data_o = wdata_q;
    assign mem_read_o       = rd_q;
    assign mem_write_o      = wr_q;

endmodule
